// File: rtl/ode_clk_en_pkg.sv
// Shared types and constants for the ODE solver clock-enable generator.
//   state_e   : controller state encoding (IDLE, RUN, DONE)
//   *_W_DEF   : default divider and step-counter widths
//   DIV_MIN   : smallest effective divider value; a requested 0 runs at this rate
package ode_clk_en_pkg;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned STEP_W_DEF = 32;
  localparam int unsigned DIV_MIN    = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ode_div_counter.sv
// Loadable down-counter with a registered zero flag. It paces the clk_en strobes.
//   clk, reset  : clock, asynchronous active-high reset
//   load_i      : load load_val_i (has priority over dec_i)
//   dec_i       : decrement by one
//   load_val_i  : value loaded on load_i
//   zero_o      : registered flag, high while the count is zero
module ode_div_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q;

  // Next count: load wins over decrement, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // The zero flag is taken from the next count so it lines up with cnt_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/ode_step_clk_en_gen.sv
// Turns the run-enable level from the clk_en PIO into a rate-divided, optionally
// step-bounded clock-enable strobe for the ODE solver datapath.
//   clk, reset  : clock, asynchronous active-high reset
//   run_en      : run level; a rising level while idle starts a run
//   div_value   : strobe period in cycles (0 acts as 1), latched at start
//   step_limit  : strobes to issue (0 = free-run), latched at start
//   clk_en      : registered solver clock-enable strobe
//   busy        : high while running
//   done        : high after a bounded run completes, until run_en drops
//   step_count  : strobes issued since the last start
module ode_step_clk_en_gen
  import ode_clk_en_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_en,
  input  logic [CNT_W-1:0]  div_value,
  input  logic [STEP_W-1:0] step_limit,
  output logic              clk_en,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step_count
);

  state_e             state_q, state_d;
  logic               run_q;
  logic               clk_en_q, clk_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [STEP_W-1:0]  step_count_q, step_count_d;
  logic [CNT_W-1:0]   div_lat_q, div_lat_d;
  logic [STEP_W-1:0]  lim_lat_q, lim_lat_d;

  logic               cnt_load, cnt_dec;
  logic [CNT_W-1:0]   cnt_load_val;
  logic               div_zero;

  logic               start_c;
  logic [CNT_W-1:0]   div_eff_c;
  logic [STEP_W-1:0]  step_inc_c;

  // A start needs a fresh rising level, so holding run_en high after DONE
  // cannot retrigger.
  assign start_c    = run_en && !run_q && (state_q == IDLE);
  assign div_eff_c  = (div_value < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : div_value;
  assign step_inc_c = step_count_q + STEP_W'(1);

  ode_div_counter #(
    .CNT_W (CNT_W)
  ) u_div_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (cnt_load_val),
    .zero_o     (div_zero)
  );

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    clk_en_d     = 1'b0;
    done_d       = done_q;
    step_count_d = step_count_q;
    div_lat_d    = div_lat_q;
    lim_lat_d    = lim_lat_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = div_lat_q - CNT_W'(1);

    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start_c) begin
          state_d      = RUN;
          div_lat_d    = div_eff_c;
          lim_lat_d    = step_limit;
          step_count_d = '0;
          cnt_load     = 1'b1;
          cnt_load_val = div_eff_c - CNT_W'(1);
        end
      end
      RUN: begin
        // Abort outranks a strobe that falls on the same edge.
        if (!run_en) begin
          state_d = IDLE;
        end else if (div_zero) begin
          clk_en_d     = 1'b1;
          cnt_load     = 1'b1;
          step_count_d = step_inc_c;
          if ((lim_lat_q != '0) && (step_inc_c == lim_lat_q)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        if (!run_en) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      run_q        <= 1'b0;
      clk_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      step_count_q <= '0;
      div_lat_q    <= '0;
      lim_lat_q    <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_en;
      clk_en_q     <= clk_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      step_count_q <= step_count_d;
      div_lat_q    <= div_lat_d;
      lim_lat_q    <= lim_lat_d;
    end
  end

  assign clk_en     = clk_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign step_count = step_count_q;

endmodule
